// File: rtl/score_tracker.sv
// Game tally for the lane droppers: score, combo, max combo, hit/miss counts, multiplier.
// Optional `define SCORE_BCD_EN adds a sequential double-dabble score_bcd/bcd_valid output pair.
module score_tracker #(
  parameter int LANES      = 4,
  parameter int HIT_POINTS = 10,
  parameter int COMBO_STEP = 10,
  parameter int MAX_MULT   = 4,
  parameter int SCORE_W    = 16
) (
  input  logic               frame_clk,
  input  logic               Reset,
  input  logic [7:0]         keycode,
  input  logic [LANES-1:0]   lane_hit,
  input  logic [LANES-1:0]   lane_done,
  output logic [SCORE_W-1:0] score,
  output logic [7:0]         combo,
  output logic [7:0]         max_combo,
  output logic [7:0]         hit_count,
  output logic [7:0]         miss_count,
  output logic [2:0]         multiplier,
  output logic               game_over,
  output logic               hit_pulse
`ifdef SCORE_BCD_EN
  ,
  output logic [19:0]        score_bcd,
  output logic               bcd_valid
`endif
);

  localparam logic [7:0] KEY_START   = 8'h2C;
  localparam logic [7:0] KEY_RESTART = 8'h01;
  localparam int         CNT_W       = $clog2(LANES + 1);
  localparam int         PROD_W      = SCORE_W + 4;
  localparam int         SUM_W       = SCORE_W + 5;

  typedef enum logic [1:0] {IDLE, PLAY, OVER} state_t;

  state_t             state, state_n;
  logic [LANES-1:0]   hit_prev, done_prev;
  logic [LANES-1:0]   hit_rise, miss_rise;
  logic [CNT_W-1:0]   h, m;
  logic [PROD_W-1:0]  product;
  logic [SUM_W-1:0]   score_sum;
  logic [SCORE_W-1:0] score_n;
  logic [8:0]         hit_sum, miss_sum, combo_sum, mult_raw;
  logic [7:0]         hit_n, miss_n, combo_n, max_n;
  logic [2:0]         mult_n;

  function automatic logic [CNT_W-1:0] popcount(input logic [LANES-1:0] v);
    logic [CNT_W-1:0] cnt;
    cnt = '0;
    for (int i = 0; i < LANES; i++) cnt = cnt + CNT_W'(v[i]);
    return cnt;
  endfunction

  // Tally arithmetic for the current cycle, all saturating.
  always_comb begin
    hit_rise  = lane_hit & ~hit_prev;
    // A lane whose hit and done rise together counts as a hit only.
    miss_rise = lane_done & ~done_prev & ~lane_hit;
    h         = popcount(hit_rise);
    m         = popcount(miss_rise);

    product   = PROD_W'(h) * PROD_W'(HIT_POINTS) * PROD_W'(multiplier);
    score_sum = SUM_W'(score) + SUM_W'(product);
    score_n   = (score_sum > SUM_W'({SCORE_W{1'b1}})) ? {SCORE_W{1'b1}} : score_sum[SCORE_W-1:0];

    hit_sum   = 9'(hit_count) + 9'(h);
    miss_sum  = 9'(miss_count) + 9'(m);
    combo_sum = 9'(combo) + 9'(h);
    hit_n     = (hit_sum  > 9'd255) ? 8'hFF : hit_sum[7:0];
    miss_n    = (miss_sum > 9'd255) ? 8'hFF : miss_sum[7:0];

    if (m != '0) combo_n = 8'd0;
    else         combo_n = (combo_sum > 9'd255) ? 8'hFF : combo_sum[7:0];
    max_n     = (combo_n > max_combo) ? combo_n : max_combo;

    mult_raw  = 9'(32'(combo_n) / COMBO_STEP) + 9'd1;
    mult_n    = (mult_raw > 9'(MAX_MULT)) ? 3'(MAX_MULT) : mult_raw[2:0];
  end

  // NOTE: every signal gets a value before the case so no latch is inferred.
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (keycode == KEY_START) state_n = PLAY;
      PLAY: begin
        if (keycode == KEY_RESTART) state_n = IDLE;
        else if (&lane_done)        state_n = OVER;
      end
      OVER:    if (keycode == KEY_RESTART) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  assign game_over = (state == OVER);

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge frame_clk) begin
    if (Reset) begin
      state      <= IDLE;
      hit_prev   <= '0;
      done_prev  <= '0;
      score      <= '0;
      combo      <= '0;
      max_combo  <= '0;
      hit_count  <= '0;
      miss_count <= '0;
      multiplier <= 3'd1;
      hit_pulse  <= 1'b0;
    end else begin
      state     <= state_n;
      hit_prev  <= lane_hit;
      done_prev <= lane_done;
      hit_pulse <= 1'b0;
      if (state_n == IDLE) begin
        score      <= '0;
        combo      <= '0;
        max_combo  <= '0;
        hit_count  <= '0;
        miss_count <= '0;
        multiplier <= 3'd1;
      end else if (state == PLAY) begin
        score      <= score_n;
        combo      <= combo_n;
        max_combo  <= max_n;
        hit_count  <= hit_n;
        miss_count <= miss_n;
        multiplier <= mult_n;
        hit_pulse  <= (h != '0);
      end
    end
  end

`ifdef SCORE_BCD_EN
  localparam int BIT_W = $clog2(SCORE_W);

  logic [SCORE_W-1:0] bcd_src, bcd_shift;
  logic [19:0]        bcd_acc, bcd_adj, bcd_acc_n;
  logic [BIT_W-1:0]   bcd_cnt;
  logic               bcd_busy;

  // One double-dabble step: add 3 to any digit >= 5, then shift in the next score bit.
  always_comb begin
    bcd_adj = bcd_acc;
    for (int i = 0; i < 5; i++) begin
      if (bcd_acc[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd_acc[4*i +: 4] + 4'd3;
    end
    bcd_acc_n = {bcd_adj[18:0], bcd_shift[SCORE_W-1]};
  end

  always_ff @(posedge frame_clk) begin
    if (Reset) begin
      bcd_src   <= '0;
      bcd_shift <= '0;
      bcd_acc   <= '0;
      bcd_cnt   <= '0;
      bcd_busy  <= 1'b0;
      score_bcd <= '0;
      bcd_valid <= 1'b1;
    end else if (score != bcd_src) begin
      bcd_src   <= score;
      bcd_shift <= score;
      bcd_acc   <= '0;
      bcd_cnt   <= '0;
      bcd_busy  <= 1'b1;
      bcd_valid <= 1'b0;
    end else if (bcd_busy) begin
      bcd_acc   <= bcd_acc_n;
      bcd_shift <= bcd_shift << 1;
      bcd_cnt   <= bcd_cnt + 1'b1;
      if (bcd_cnt == BIT_W'(SCORE_W - 1)) begin
        bcd_busy  <= 1'b0;
        bcd_valid <= 1'b1;
        score_bcd <= bcd_acc_n;
      end
    end
  end
`endif

endmodule

// File: tb/tb_score_tracker.sv
// Self-checking bench for score_tracker: directed game scenarios plus random play,
// every cycle scored against a behavioural tally model through an expectation queue.
module tb_score_tracker;

  localparam int LANES      = 4;
  localparam int HIT_POINTS = 10;
  localparam int COMBO_STEP = 10;
  localparam int MAX_MULT   = 4;
  localparam int SCORE_MAX  = 65535;

  logic        frame_clk = 1'b0;
  logic        Reset;
  logic [7:0]  keycode;
  logic [3:0]  lane_hit, lane_done;
  logic [15:0] score;
  logic [7:0]  combo, max_combo, hit_count, miss_count;
  logic [2:0]  multiplier;
  logic        game_over, hit_pulse;
`ifdef SCORE_BCD_EN
  logic [19:0] score_bcd;
  logic        bcd_valid;
`endif

  always #5 frame_clk = ~frame_clk;

  score_tracker dut (
    .frame_clk  (frame_clk),
    .Reset      (Reset),
    .keycode    (keycode),
    .lane_hit   (lane_hit),
    .lane_done  (lane_done),
    .score      (score),
    .combo      (combo),
    .max_combo  (max_combo),
    .hit_count  (hit_count),
    .miss_count (miss_count),
    .multiplier (multiplier),
    .game_over  (game_over),
    .hit_pulse  (hit_pulse)
`ifdef SCORE_BCD_EN
    ,
    .score_bcd  (score_bcd),
    .bcd_valid  (bcd_valid)
`endif
  );

  typedef struct packed {
    logic [15:0] score;
    logic [7:0]  combo;
    logic [7:0]  max_combo;
    logic [7:0]  hits;
    logic [7:0]  misses;
    logic [2:0]  mult;
    logic        over;
    logic        pulse;
  } snap_t;

  snap_t exp_q[$];
  snap_t mon_exp, mon_act;
  int    checks = 0;
  int    errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, expv, $time);
    end
  endtask

  // Behavioural model: game phase flags and plain integer tallies.
  bit         m_playing, m_over, m_pulse;
  int         m_score, m_combo, m_max, m_hits, m_misses, m_mult;
  logic [3:0] m_hit_prev, m_done_prev;

  function automatic int imin(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  task automatic model_clear();
    m_score = 0; m_combo = 0; m_max = 0; m_hits = 0; m_misses = 0; m_mult = 1;
  endtask

  task automatic model_step(input logic rst, input logic [7:0] key,
                            input logic [3:0] hit, input logic [3:0] done);
    int h, mm;
    if (rst) begin
      model_clear();
      m_playing = 0; m_over = 0; m_pulse = 0;
      m_hit_prev = '0; m_done_prev = '0;
      return;
    end
    h = 0; mm = 0;
    for (int i = 0; i < LANES; i++) begin
      if (hit[i] && !m_hit_prev[i]) h++;
      if (done[i] && !m_done_prev[i] && !hit[i]) mm++;
    end
    m_pulse = 0;
    if (m_playing) begin
      if (key == 8'h01) begin
        model_clear();
        m_playing = 0;
      end else begin
        m_score  = imin(SCORE_MAX, m_score + h * HIT_POINTS * m_mult);
        m_hits   = imin(255, m_hits + h);
        m_misses = imin(255, m_misses + mm);
        m_combo  = (mm > 0) ? 0 : imin(255, m_combo + h);
        if (m_combo > m_max) m_max = m_combo;
        m_mult   = imin(MAX_MULT, 1 + m_combo / COMBO_STEP);
        m_pulse  = (h > 0);
        if (done == 4'b1111) begin
          m_playing = 0;
          m_over    = 1;
        end
      end
    end else if (m_over) begin
      if (key == 8'h01) begin
        model_clear();
        m_over = 0;
      end
    end else if (key == 8'h2C) begin
      m_playing = 1;
    end
    m_hit_prev  = hit;
    m_done_prev = done;
  endtask

  task automatic step(input logic rst, input logic [7:0] key,
                      input logic [3:0] hit, input logic [3:0] done);
    snap_t e;
    Reset = rst; keycode = key; lane_hit = hit; lane_done = done;
    model_step(rst, key, hit, done);
    e.score = 16'(m_score);   e.combo  = 8'(m_combo); e.max_combo = 8'(m_max);
    e.hits  = 8'(m_hits);     e.misses = 8'(m_misses); e.mult     = 3'(m_mult);
    e.over  = m_over;         e.pulse  = m_pulse;
    exp_q.push_back(e);
    @(posedge frame_clk);
    #2;
  endtask

  // Monitor: one expectation is due after every clock edge that had stimulus.
  always @(posedge frame_clk) begin
    #1;
    if (exp_q.size() > 0) begin
      mon_exp = exp_q.pop_front();
      mon_act.score = score;       mon_act.combo  = combo;      mon_act.max_combo = max_combo;
      mon_act.hits  = hit_count;   mon_act.misses = miss_count; mon_act.mult      = multiplier;
      mon_act.over  = game_over;   mon_act.pulse  = hit_pulse;
      check("tally", 64'(mon_act), 64'(mon_exp));
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] hl, dl;
    step(1, 8'h00, 4'h0, 4'h0);
    step(1, 8'h2C, 4'h1, 4'h1);
    check("reset_score", 64'(score), 64'd0);
    check("reset_mult", 64'(multiplier), 64'd1);

    // First hit, with done rising on the same lane.
    step(0, 8'h2C, 4'h0, 4'h0);
    step(0, 8'h00, 4'h1, 4'h1);
    check("first_score", 64'(score), 64'd10);
    check("first_pulse", 64'(hit_pulse), 64'd1);
    step(0, 8'h00, 4'h1, 4'h1);
    check("pulse_one_cycle", 64'(hit_pulse), 64'd0);

    // Twelve hits: multiplier steps to 2 after the tenth.
    step(0, 8'h01, 4'h0, 4'h0);
    step(0, 8'h2C, 4'h0, 4'h0);
    for (int i = 0; i < 12; i++) begin
      step(0, 8'h00, 4'h1, 4'h1);
      step(0, 8'h00, 4'h0, 4'h0);
    end
    check("combo12_score", 64'(score), 64'd140);
    check("combo12_combo", 64'(combo), 64'd12);
    check("combo12_mult", 64'(multiplier), 64'd2);
`ifdef SCORE_BCD_EN
    step(0, 8'h00, 4'h0, 4'h0);
    step(0, 8'h00, 4'h0, 4'h0);
    begin
      int n = 0;
      while (!bcd_valid && n < 40) begin
        step(0, 8'h00, 4'h0, 4'h0);
        n++;
      end
    end
    check("bcd_valid", 64'(bcd_valid), 64'd1);
    check("bcd_value", 64'(score_bcd), 64'h00140);
`endif

    // Combo of five, then a miss on lane 2.
    step(0, 8'h01, 4'h0, 4'h0);
    step(0, 8'h2C, 4'h0, 4'h0);
    for (int i = 0; i < 5; i++) begin
      step(0, 8'h00, 4'h2, 4'h2);
      step(0, 8'h00, 4'h0, 4'h0);
    end
    step(0, 8'h00, 4'h0, 4'h4);
    check("miss_count", 64'(miss_count), 64'd1);
    check("miss_combo", 64'(combo), 64'd0);
    check("miss_max", 64'(max_combo), 64'd5);
    check("miss_mult", 64'(multiplier), 64'd1);
    step(0, 8'h00, 4'h0, 4'h0);

    // Two hits alongside a miss on lane 3.
    step(0, 8'h00, 4'h3, 4'hB);
    check("mixed_score", 64'(score), 64'd70);
    check("mixed_hits", 64'(hit_count), 64'd7);
    check("mixed_misses", 64'(miss_count), 64'd2);
    check("mixed_combo", 64'(combo), 64'd0);
    step(0, 8'h00, 4'h0, 4'h0);

    // All lanes done: game over, tally frozen, restart clears.
    step(0, 8'h00, 4'h0, 4'hF);
    check("over_flag", 64'(game_over), 64'd1);
    step(0, 8'h00, 4'hF, 4'hF);
    check("over_frozen", 64'(score), 64'd70);
    step(0, 8'h01, 4'hF, 4'h0);
    check("restart_score", 64'(score), 64'd0);
    check("restart_over", 64'(game_over), 64'd0);

    // Levels already high at start are not scored.
    step(0, 8'h2C, 4'hF, 4'h0);
    step(0, 8'h00, 4'hF, 4'h0);
    step(0, 8'h00, 4'hF, 4'h0);
    check("stale_hits", 64'(hit_count), 64'd0);

    // Drive the score into saturation with four-lane hits.
    for (int i = 0; i < 450; i++) begin
      step(0, 8'h00, 4'h0, 4'h0);
      step(0, 8'h00, 4'hF, 4'h0);
    end
    check("sat_score", 64'(score), 64'd65535);
    check("sat_combo", 64'(combo), 64'd255);
    check("sat_hits", 64'(hit_count), 64'd255);
    check("sat_mult", 64'(multiplier), 64'd4);

    // Random play against the model.
    step(1, 8'h00, 4'h0, 4'h0);
    hl = '0; dl = '0;
    for (int i = 0; i < 2500; i++) begin
      int r;
      logic [7:0] k;
      for (int j = 0; j < LANES; j++) begin
        if ($urandom_range(0, 3) == 0) hl[j] = ~hl[j];
        if ($urandom_range(0, 3) == 0) dl[j] = ~dl[j];
      end
      r = $urandom_range(0, 19);
      if (r == 0)      k = 8'h2C;
      else if (r == 1) k = 8'h01;
      else             k = 8'($urandom_range(0, 255));
      step(($urandom_range(0, 299) == 0), k, hl, dl);
    end

    check("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/score_tracker.md
Name: score_tracker

Overview:
Downstream of the lane droppers. Consumes each lane's hit level (scoreN) and done level (finish) and keeps the game tally: score, combo, max combo, hit and miss counts, and the combo multiplier. Outputs feed the text/digit renderer and the end-of-song screen. Runs on the same frame-rate clock and keyboard start/restart keys as the droppers.

Parameters:
LANES, 4, number of dropper lanes
HIT_POINTS, 10, base points per hit (before multiplier)
COMBO_STEP, 10, combo hits needed per multiplier increment
MAX_MULT, 4, multiplier ceiling (1..MAX_MULT)
SCORE_W, 16, score width

Ports:
frame_clk  in  1  frame-rate clock
Reset  in  1  synchronous, active-high
keycode  in  8  current keyboard code; 8'h2C = start, 8'h01 = restart
lane_hit  in  LANES  per-lane hit level; stays high until that lane's dropper re-halts
lane_done  in  LANES  per-lane finished level (hit or fell past Y_Max)
score  out  SCORE_W  accumulated points, saturating
combo  out  8  current consecutive hits, saturating at 255
max_combo  out  8  highest combo this game
hit_count  out  8  total hits, saturating
miss_count  out  8  total misses, saturating
multiplier  out  3  current multiplier, 1..MAX_MULT
game_over  out  1  high in OVER
hit_pulse  out  1  one-cycle pulse on any scored hit

Behaviour:
- Reset is synchronous, active-high, on the frame_clk edge. All state registers update on posedge frame_clk.
- Reset: state=IDLE, all counters 0, multiplier=1, game_over=0, hit_pulse=0, edge registers 0.
- Edge detect: hit_prev and done_prev registered per lane.
  - hit_rise = lane_hit & ~hit_prev.
  - miss_rise = lane_done & ~done_prev & ~lane_hit. A lane whose hit and done rise in the same cycle is a hit, not a miss.
- IDLE:
  - Counters held at 0, multiplier=1.
  - hit_prev<=lane_hit and done_prev<=lane_done every cycle, so stale levels are never scored.
  - keycode==8'h2C -> PLAY next cycle.
- PLAY: each cycle, with h = popcount(hit_rise) and m = popcount(miss_rise):
  - score += h*HIT_POINTS*multiplier, using the multiplier registered before this cycle; saturates at 2^SCORE_W-1.
  - hit_count += h; miss_count += m; both saturate at 255.
  - If m>0: combo <= 0. Hits in the same cycle still score, but the combo still resets.
  - Otherwise combo <= sat255(combo+h).
  - max_combo <= max(max_combo, new combo).
  - multiplier <= min(MAX_MULT, 1 + new_combo/COMBO_STEP).
  - hit_pulse = 1 for exactly the cycle after a cycle with h>0 (registered).
  - Transition to OVER when all bits of lane_done are 1 after updating; the final cycle's hits and misses are counted.
  - keycode==8'h01 in PLAY -> IDLE, counters cleared.
- OVER:
  - All tallies frozen; game_over=1; edge registers still track inputs.
  - keycode==8'h01 -> IDLE; counters clear on entry to IDLE.
- Arithmetic:
  - Product h*HIT_POINTS*multiplier computed at SCORE_W+4 bits; the saturating add compares against max before truncation.
  - combo/COMBO_STEP done by constant divide; synthesisable for constant parameters.
- Reset in any state overrides everything, including a same-cycle keycode or hit.

Optional Feature:
SCORE_BCD_EN:
- Defined: adds outputs score_bcd[19:0] (5 BCD digits) and bcd_valid.
- A sequential double-dabble converter restarts whenever score changes. It takes SCORE_W cycles, one shift-add-3 per cycle.
  - bcd_valid=0 while converting; score_bcd holds the previous result until done, then updates and bcd_valid=1.
  - A score change mid-conversion restarts the conversion.
- Reset: score_bcd=0, bcd_valid=1.
- Not defined: ports absent, no converter logic.

Test Plan:
- Reset, keycode 2C, single rising lane_hit[0] together with lane_done[0] -> score=10, combo=1, hit_count=1, miss_count=0, hit_pulse high one cycle.
- 12 sequential single-lane hits -> combo=12, multiplier=2 after the 10th hit, score=10*10+2*20=140.
- Combo of 5, then lane_done[2] rises with lane_hit[2]=0 -> miss_count=1, combo=0, max_combo=5, multiplier=1.
- lane_hit[0] and lane_hit[1] rise in the same cycle as a miss on lane 3 -> score +20, hit_count +2, miss_count +1, combo=0.
- All lane_done high -> game_over=1, and further hit edges do not change the tally. Keycode 01 -> IDLE with all counters 0. Lane levels already high at start are not counted after 2C.
- Score driven near 65530 with multiplier 4 -> score saturates at 65535. With SCORE_BCD_EN: score 140 -> within 16 cycles bcd_valid=1, score_bcd=20'h00140.
